// File: rtl/stack_up_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_up_arbiter_pkg
// Summary  : stack-up cntl encodings, default field widths and word classifiers
// Revision : 1.0
// ============================================================================
package stack_up_arbiter_pkg;

   localparam int STU_CNTL_WIDTH = 2;
   localparam int STU_TYPE_WIDTH = 2;
   localparam int STU_DATA_WIDTH = 64;
   localparam int STU_OOB_WIDTH  = 32;

   typedef enum logic [1:0] {
      CNTL_MOM     = 2'b00,
      CNTL_SOM     = 2'b01,
      CNTL_EOM     = 2'b10,
      CNTL_SOM_EOM = 2'b11
   } cntl_e;

   function automatic logic is_start(input logic [1:0] cntl);
      return (cntl == CNTL_SOM) || (cntl == CNTL_SOM_EOM);
   endfunction

   function automatic logic is_end(input logic [1:0] cntl);
      return (cntl == CNTL_EOM) || (cntl == CNTL_SOM_EOM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stack_up_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_up_arbiter_if
// Summary  : requester-side and stack-up-side handshake buses of the arbiter
// Revision : 1.0
// ============================================================================
interface stack_up_arbiter_if
   import stack_up_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = STU_DATA_WIDTH,
   parameter int TYPE_WIDTH = STU_TYPE_WIDTH,
   parameter int OOB_WIDTH  = STU_OOB_WIDTH,
   parameter int CNTL_WIDTH = STU_CNTL_WIDTH
);

   logic [NUM_REQ-1:0]            req__arb__valid;
   logic [NUM_REQ*CNTL_WIDTH-1:0] req__arb__cntl;
   logic [NUM_REQ-1:0]            arb__req__ready;
   logic [NUM_REQ*TYPE_WIDTH-1:0] req__arb__type;
   logic [NUM_REQ*DATA_WIDTH-1:0] req__arb__data;
   logic [NUM_REQ*OOB_WIDTH-1:0]  req__arb__oob_data;

   logic                          mgr__stu__valid;
   logic [CNTL_WIDTH-1:0]         mgr__stu__cntl;
   logic                          stu__mgr__ready;
   logic [TYPE_WIDTH-1:0]         mgr__stu__type;
   logic [DATA_WIDTH-1:0]         mgr__stu__data;
   logic [OOB_WIDTH-1:0]          mgr__stu__oob_data;

   modport master (
      input  req__arb__valid, req__arb__cntl, req__arb__type,
      input  req__arb__data, req__arb__oob_data, stu__mgr__ready,
      output arb__req__ready, mgr__stu__valid, mgr__stu__cntl,
      output mgr__stu__type, mgr__stu__data, mgr__stu__oob_data
   );

   modport slave (
      output req__arb__valid, req__arb__cntl, req__arb__type,
      output req__arb__data, req__arb__oob_data, stu__mgr__ready,
      input  arb__req__ready, mgr__stu__valid, mgr__stu__cntl,
      input  mgr__stu__type, mgr__stu__data, mgr__stu__oob_data
   );

endinterface
`default_nettype wire

// File: rtl/stack_up_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stack_up_arb_fifo
// Summary  : 2-entry registered FIFO; a push into a full FIFO is taken when a pop frees a slot
// Revision : 1.0
// ============================================================================
module stack_up_arb_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_poweron,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = pop && (r_count != 2'd0);
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // When full the write slot equals the head slot; the head is consumed at this edge
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign empty = (r_count == 2'd0);
   assign full  = (r_count == 2'd2);

endmodule
`default_nettype wire

// File: rtl/stack_up_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_up_arbiter
// Summary  : packet-level round-robin arbiter of NUM_REQ sources onto one stack-up bus
// Revision : 1.0
// ============================================================================
module stack_up_arbiter
   import stack_up_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = STU_DATA_WIDTH,
   parameter int TYPE_WIDTH = STU_TYPE_WIDTH,
   parameter int OOB_WIDTH  = STU_OOB_WIDTH,
   parameter int CNTL_WIDTH = STU_CNTL_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset_poweron,
   stack_up_arbiter_if.master         bus,
   output logic [$clog2(NUM_REQ)-1:0] arb__sys__grant_id,
   output logic                       arb__sys__busy,
   output logic                       arb__sys__proto_err
);

   localparam int GW      = $clog2(NUM_REQ);
   localparam int ENTRY_W = CNTL_WIDTH + TYPE_WIDTH + DATA_WIDTH + OOB_WIDTH;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [GW-1:0]         r_rr_ptr;
   logic [GW-1:0]         r_grant;
   logic                  r_proto_err;

   logic [CNTL_WIDTH-1:0] w_cntl [NUM_REQ];
   logic [TYPE_WIDTH-1:0] w_type [NUM_REQ];
   logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
   logic [OOB_WIDTH-1:0]  w_oob  [NUM_REQ];
   logic [NUM_REQ-1:0]    w_cand;
   logic [NUM_REQ-1:0]    w_stray;

   logic                  w_win_found;
   logic [GW-1:0]         w_win_idx;
   logic [NUM_REQ-1:0]    w_ready;
   logic                  w_push;
   logic [CNTL_WIDTH-1:0] w_push_cntl;
   logic [GW-1:0]         w_sel;
   logic                  w_err_set;
   logic                  w_pkt_end;
   logic                  w_grant_load;

   logic                  w_space;
   logic                  w_empty;
   logic                  w_full;
   logic [ENTRY_W-1:0]    w_head;

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign w_cntl[g]  = bus.req__arb__cntl[g*CNTL_WIDTH +: CNTL_WIDTH];
         assign w_type[g]  = bus.req__arb__type[g*TYPE_WIDTH +: TYPE_WIDTH];
         assign w_data[g]  = bus.req__arb__data[g*DATA_WIDTH +: DATA_WIDTH];
         assign w_oob[g]   = bus.req__arb__oob_data[g*OOB_WIDTH +: OOB_WIDTH];
         assign w_cand[g]  = bus.req__arb__valid[g] && is_start(w_cntl[g]);
         assign w_stray[g] = bus.req__arb__valid[g] && !is_start(w_cntl[g]);
      end
   endgenerate

   assign w_space = !w_full || (!w_empty && bus.stu__mgr__ready);

   // Descending scan so the candidate nearest rr_ptr (upward, wrapping) wins
   always_comb begin : p_winner
      int idx;
      idx         = 0;
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (w_cand[idx]) begin
            w_win_found = 1'b1;
            w_win_idx   = GW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_push && !w_pkt_end) w_state_nxt = ST_LOCKED;
         ST_LOCKED: if (w_pkt_end) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready      = '0;
      w_push       = 1'b0;
      w_sel        = w_win_idx;
      w_push_cntl  = w_cntl[w_win_idx];
      w_err_set    = 1'b0;
      w_pkt_end    = 1'b0;
      w_grant_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_space) begin
               // Stray continuation words are swallowed so they cannot stall the port
               w_ready   = w_stray;
               w_err_set = |w_stray;
               if (w_win_found) begin
                  w_ready[w_win_idx] = 1'b1;
                  w_push             = 1'b1;
                  w_grant_load       = 1'b1;
                  w_pkt_end          = is_end(w_cntl[w_win_idx]);
               end
            end
         end
         ST_LOCKED: begin
            w_sel            = r_grant;
            w_push_cntl      = w_cntl[r_grant];
            w_ready[r_grant] = w_space;
            if (w_space && bus.req__arb__valid[r_grant]) begin
               w_push = 1'b1;
               if (is_start(w_cntl[r_grant])) begin
                  w_push_cntl = CNTL_WIDTH'(CNTL_EOM);
                  w_err_set   = 1'b1;
                  w_pkt_end   = 1'b1;
               end else begin
                  w_pkt_end = is_end(w_cntl[r_grant]);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_grant_load) begin
            r_grant <= w_win_idx;
         end
         if (w_pkt_end) begin
            r_rr_ptr <= (w_sel == GW'(NUM_REQ - 1)) ? '0 : w_sel + GW'(1);
         end
         if (w_err_set) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   stack_up_arb_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (w_push),
      .push_data     ({w_push_cntl, w_type[w_sel], w_data[w_sel], w_oob[w_sel]}),
      .pop           (bus.stu__mgr__ready),
      .head          (w_head),
      .empty         (w_empty),
      .full          (w_full)
   );

   assign bus.arb__req__ready    = w_ready;
   assign bus.mgr__stu__valid    = !w_empty;
   assign bus.mgr__stu__cntl     = w_head[ENTRY_W-1 -: CNTL_WIDTH];
   assign bus.mgr__stu__type     = w_head[DATA_WIDTH+OOB_WIDTH +: TYPE_WIDTH];
   assign bus.mgr__stu__data     = w_head[OOB_WIDTH +: DATA_WIDTH];
   assign bus.mgr__stu__oob_data = w_head[OOB_WIDTH-1:0];

   assign arb__sys__grant_id  = r_grant;
   assign arb__sys__busy      = (r_state == ST_LOCKED) || !w_empty;
   assign arb__sys__proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: doc/stack_up_arbiter.md
Name: stack_up_arbiter

Overview:
- Packet-level round-robin arbiter sharing the manager's single upstream stack bus (mgr__stu__*) among NUM_REQ internal sources, e.g. the DMA return path and the control/status path.
- A packet, delimited by SOM and EOM in cntl, is never interleaved.
- Accepted words pass through a 2-entry output FIFO, so the stack-bus outputs are registered and the link sustains one word per cycle.
- Sits between the manager's internal requesters and the stack upstream port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 64, width of the stack-up data word.
- TYPE_WIDTH, 2, width of the stack-up type field (control/data, vector/scalar).
- OOB_WIDTH, 32, width of the out-of-band data.
- CNTL_WIDTH, 2, width of the standard-interface cntl field.

Ports:
- clk  in  1  system clock.
- reset_poweron  in  1  asynchronous, active-high reset.
- req__arb__valid  in  NUM_REQ  per-requester word valid.
- req__arb__cntl  in  NUM_REQ*CNTL_WIDTH  per-requester SOM/MOM/EOM/SOM_EOM.
- arb__req__ready  out  NUM_REQ  per-requester accept.
- req__arb__type  in  NUM_REQ*TYPE_WIDTH  per-requester type.
- req__arb__data  in  NUM_REQ*DATA_WIDTH  per-requester data.
- req__arb__oob_data  in  NUM_REQ*OOB_WIDTH  per-requester OOB data.
- mgr__stu__valid  out  1  stack-up valid.
- mgr__stu__cntl  out  CNTL_WIDTH  stack-up cntl.
- stu__mgr__ready  in  1  stack-up ready.
- mgr__stu__type  out  TYPE_WIDTH  stack-up type.
- mgr__stu__data  out  DATA_WIDTH  stack-up data.
- mgr__stu__oob_data  out  OOB_WIDTH  stack-up OOB data.
- arb__sys__grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- arb__sys__busy  out  1  high while a packet is locked or the FIFO is non-empty.
- arb__sys__proto_err  out  1  sticky protocol-error flag.

Behaviour:
- **Clock and reset:** one clock, clk. reset_poweron is asynchronous and active-high.
- **Reset values:** all outputs 0, FIFO empty, state IDLE, rr_ptr=0, proto_err=0.
- **Reset mid-packet:** the partial packet is dropped. No EOM is emitted for it.
- **Cntl encoding:**
  - SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11.
  - A word is a start word if its cntl is SOM or SOM_EOM.
  - A word is an end word if its cntl is EOM or SOM_EOM.
- **Handshakes:**
  - A transfer occurs when valid and ready are both high in the same cycle, on either side.
  - Each requester must hold valid and all fields stable until ready.
  - The stack side obeys the same rule: outputs stay stable until stu__mgr__ready.
- **FIFO:**
  - 2 entries; each entry holds {cntl, type, data, oob}.
  - The outputs are driven from the head entry; mgr__stu__valid = !empty.
  - A simultaneous push and pop when the FIFO is full is allowed, because the pop frees an entry.
  - space = !full || (mgr__stu__valid && stu__mgr__ready).
- **State IDLE:**
  - Candidates are requesters with valid=1 and a start word.
  - The winner is the first candidate at or after rr_ptr, searching upward with wrap-around.
  - If space=1, set arb__req__ready[winner]=1 in the same cycle (combinational) and push the word.
  - grant_id <= winner.
  - Next state is LOCKED if the word is SOM; stays IDLE if it is SOM_EOM.
  - On an end word, rr_ptr <= winner+1 mod NUM_REQ.
- **State LOCKED:**
  - Only the granted requester gets ready: arb__req__ready[grant]=space.
  - Each accepted word is pushed to the FIFO.
  - On an accepted end word: rr_ptr <= grant+1 mod NUM_REQ and next state is IDLE.
  - The next grant can occur in the cycle immediately after an EOM, with no bubble.
- **Protocol errors:**
  - In IDLE, a valid non-start word from a requester that has no other valid start word this cycle is accepted and discarded (ready=1, no push), and sets proto_err.
  - In LOCKED, an SOM or SOM_EOM from the granted requester is forwarded with cntl forced to EOM, sets proto_err, and returns the state to IDLE.
  - proto_err clears only on reset.
- **Latency:**
  - A word accepted in cycle N appears on mgr__stu__* in cycle N+1 if the FIFO was empty.
  - Throughput is 1 word/cycle while stu__mgr__ready=1.
- **Backpressure:** while the FIFO is full and stu__mgr__ready=0, all arb__req__ready=0. No word is ever lost or duplicated.
- **Busy:** arb__sys__busy = (state==LOCKED) || !empty.

Decomposition:
- Shared package (stack_interface.vh):
  - cntl encodings: SOM, MOM, EOM, SOM_EOM.
  - Default stack-up TYPE/DATA/OOB widths.
- Sub-module stack_up_arb_fifo: the 2-entry registered FIFO, parameterised on entry width, with full/empty and a push/pop-when-full bypass.
- The arbitration FSM and rr pointer stay in the top module.

Test Plan:
1. **Single requester:** req0 sends SOM, MOM, EOM with data 0x11, 0x22, 0x33; stu ready held 1 -> mgr__stu__valid on cycles N+1..N+3 with the same data and cntl 01/00/10; grant_id=0; rr_ptr=1 afterwards.
2. **Contention:** req0 and req1 both present 4-word packets at rr_ptr=0 -> all of req0's packet, then all of req1's starting the cycle after req0's EOM; no interleaving; rr_ptr returns to 0.
3. **Backpressure:** stu__mgr__ready=0 for 5 cycles mid-packet -> the FIFO fills with 2 entries, arb__req__ready goes 0, and the outputs stay stable; on ready=1 all words are delivered in order with no duplicates.
4. **Single-word packets:** req1 sends SOM_EOM 0xAA while req0 idles -> 0xAA appears one cycle later with cntl 11; state stays IDLE; rr_ptr=0.
5. **Protocol error:**
   - req0 sends MOM while IDLE -> the word is discarded and proto_err=1.
   - Then req0 sends SOM mid-packet -> it is forwarded as EOM, the FSM returns to IDLE, and proto_err stays 1.
6. **Reset mid-packet:** assert reset_poweron after the 2nd of 4 words -> all outputs 0 immediately, FIFO empty; a new packet after reset is forwarded normally from rr_ptr=0.
